// File: rtl/fpga_mode_pkg.sv
// Shared definitions for the mode controller: FSM state encoding, request encoding
// and the index-width helper.
package fpga_mode_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;

  // A request is carried as {valid, index}; valid at this value means "no mode selected".
  localparam logic ReqNone = 1'b0;

  // $clog2 clamped to at least one bit so a single-mode build still has an index port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-FF synchronizer followed by a stability counter.
// The accepted value changes only after DB_CYCLES consecutive identical synchronized samples
// that differ from the current accepted value; any change in the sample restarts the count.
module sw_debounce
  import fpga_mode_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sel_raw,
  output logic [WIDTH-1:0] sel_stable
);

  localparam int unsigned CntW = clog2_min1(DB_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  cnt_inc;

  // Two-stage synchronizer; sync1_q is the metastability-settling stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sel_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples equal to the candidate; accept once DB_CYCLES are seen.
  always_comb begin
    cand_d   = sync2_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // A sample differing from the previous candidate is the first of a new run.
    cnt_inc  = (sync2_q == cand_q) ? cnt_q + 1'b1 : CntW'(1);
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= CntW'(DB_CYCLES)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sel_stable = stable_q;

endmodule

// File: rtl/fpga_mode_ctrl.sv
// Registered mode selector for the watch / HC-SR04 / DHT-11 sub-blocks.
// Debounced switches are priority encoded (highest index wins) and drive one-hot level
// start enables. Mode changes are break-before-make: the running block is stopped and
// must drop busy before the next block is started.
// Optional feature macro: FPGA_MODE_TIMEOUT_EN adds a DRAIN timeout and the sticky
// timeout_err output.
module fpga_mode_ctrl
  import fpga_mode_pkg::*;
#(
  parameter int unsigned N_MODE         = 3,
  parameter int unsigned DB_CYCLES      = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned IDX_W          = clog2_min1(N_MODE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_MODE-1:0] sel,
  input  logic [N_MODE-1:0] busy,
  output logic [N_MODE-1:0] start,
  output logic [IDX_W-1:0]  active_mode,
  output logic              mode_valid,
  output logic              switching,
  output logic              mode_chg
`ifdef FPGA_MODE_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  // Reject parameter sets the datapath cannot represent.
  if (N_MODE < 1 || DB_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      IDX_W < clog2_min1(N_MODE)) begin : g_param_check
    $error("fpga_mode_ctrl: illegal parameter combination");
  end

  logic [N_MODE-1:0] sel_acc;
  logic              req_vld;
  logic [IDX_W-1:0]  req_idx;

  state_t            state_q, state_d;
  logic [N_MODE-1:0] start_q, start_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic              tgt_vld_q, tgt_vld_d;
  logic [IDX_W-1:0]  tgt_idx_q, tgt_idx_d;
  logic              chg_q, chg_d;
  logic              drain_exit;

`ifdef FPGA_MODE_TIMEOUT_EN
  localparam int unsigned TmoW = clog2_min1(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_err_q, tmo_err_d;
  logic            tmo_hit;
`endif

  function automatic logic [N_MODE-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_MODE-1:0] v;
    v = '0;
    for (int i = 0; i < N_MODE; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  sw_debounce #(
    .WIDTH     (N_MODE),
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_raw    (sel),
    .sel_stable (sel_acc)
  );

  // Priority encoder: later (higher) set bits overwrite lower ones.
  always_comb begin
    req_vld = ReqNone;
    req_idx = '0;
    for (int i = 0; i < N_MODE; i++) begin
      if (sel_acc[i]) begin
        req_vld = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
  end

  // DRAIN exit: the stopped block reports idle, or optionally the wait times out.
`ifdef FPGA_MODE_TIMEOUT_EN
  always_comb begin
    tmo_hit    = busy[cur_q] && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    drain_exit = !busy[cur_q] || tmo_hit;
  end
`else
  always_comb begin
    drain_exit = !busy[cur_q];
  end
`endif

  // Mode FSM next-state and output-register next values.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    cur_d     = cur_q;
    tgt_vld_d = tgt_vld_q;
    tgt_idx_d = tgt_idx_q;
    chg_d     = 1'b0;
`ifdef FPGA_MODE_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_vld) begin
          start_d = onehot(req_idx);
          cur_d   = req_idx;
          chg_d   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Covers both a different mode and all switches off.
        if (!req_vld || (req_idx != cur_q)) begin
          start_d   = '0;
          chg_d     = 1'b1;
          tgt_vld_d = req_vld;
          tgt_idx_d = req_idx;
          state_d   = StDrain;
`ifdef FPGA_MODE_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      StDrain: begin
        // cur_q still names the stopped block, so busy[cur_q] is the one being drained.
        tgt_vld_d = req_vld;
        tgt_idx_d = req_idx;
`ifdef FPGA_MODE_TIMEOUT_EN
        if (tmo_hit) begin
          tmo_err_d = 1'b1;
        end else if (busy[cur_q]) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
        if (drain_exit) begin
          if (tgt_vld_q) begin
            start_d = onehot(tgt_idx_q);
            cur_d   = tgt_idx_q;
            chg_d   = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      start_q   <= '0;
      cur_q     <= '0;
      tgt_vld_q <= ReqNone;
      tgt_idx_q <= '0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cur_q     <= cur_d;
      tgt_vld_q <= tgt_vld_d;
      tgt_idx_q <= tgt_idx_d;
      chg_q     <= chg_d;
    end
  end

`ifdef FPGA_MODE_TIMEOUT_EN
  // DRAIN timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`endif

  assign start       = start_q;
  assign mode_valid  = |start_q;
  assign active_mode = mode_valid ? cur_q : '0;
  assign switching   = (state_q == StDrain);
  assign mode_chg    = chg_q;

endmodule

// File: tb/tb_fpga_mode_ctrl.sv
// Directed bench for fpga_mode_ctrl with DB_CYCLES=4, TIMEOUT_CYCLES=8, N_MODE=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fpga_mode_ctrl;

  localparam int unsigned NMode   = 3;
  localparam int unsigned DbCyc   = 4;
  localparam int unsigned TmoCyc  = 8;
  localparam int unsigned IdxW    = 2;
  localparam int unsigned Latency = DbCyc + 3;

  logic            clk;
  logic            rst_n;
  logic [NMode-1:0] sel;
  logic [NMode-1:0] busy;
  logic [NMode-1:0] start;
  logic [IdxW-1:0]  active_mode;
  logic             mode_valid;
  logic             switching;
  logic             mode_chg;
`ifdef FPGA_MODE_TIMEOUT_EN
  logic             timeout_err;
`endif

  int n_vec;
  int n_err;
  logic multi_hot;
  logic glitch_seen;

  fpga_mode_ctrl #(
    .N_MODE         (NMode),
    .DB_CYCLES      (DbCyc),
    .TIMEOUT_CYCLES (TmoCyc),
    .IDX_W          (IdxW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .busy        (busy),
    .start       (start),
    .active_mode (active_mode),
    .mode_valid  (mode_valid),
    .switching   (switching),
    .mode_chg    (mode_chg)
`ifdef FPGA_MODE_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch for any multi-hot start (which also covers old and new both set).
  always @(negedge clk) begin
    if ($countones(start) > 1) multi_hot = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    multi_hot = 1'b0;
    rst_n     = 1'b0;
    sel       = '0;
    busy      = '0;
    step(2);
    check_eq("rst_start", 32'(start), 32'h0);
    check_eq("rst_active_mode", 32'(active_mode), 32'h0);
    check_eq("rst_mode_valid", 32'(mode_valid), 32'h0);
    check_eq("rst_switching", 32'(switching), 32'h0);
    check_eq("rst_mode_chg", 32'(mode_chg), 32'h0);
`ifdef FPGA_MODE_TIMEOUT_EN
    check_eq("rst_timeout_err", 32'(timeout_err), 32'h0);
`endif
    rst_n = 1'b1;
    step(1);

    // 1: mode 0 from IDLE, start rises exactly DB_CYCLES+3 edges later.
    sel = 3'b001;
    step(Latency - 1);
    check_eq("t1_start_early", 32'(start), 32'h0);
    step(1);
    check_eq("t1_start", 32'(start), 32'h1);
    check_eq("t1_mode_chg", 32'(mode_chg), 32'h1);
    check_eq("t1_active_mode", 32'(active_mode), 32'h0);
    check_eq("t1_mode_valid", 32'(mode_valid), 32'h1);
    step(1);
    check_eq("t1_chg_pulse_end", 32'(mode_chg), 32'h0);

    // 2: a 3-cycle glitch is shorter than the debounce window.
    glitch_seen = 1'b0;
    sel = 3'b010;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) sel = 3'b001;
      step(1);
      if (mode_chg || start != 3'b001 || switching) glitch_seen = 1'b1;
    end
    check_eq("t2_glitch_effect", 32'(glitch_seen), 32'h0);
    check_eq("t2_start", 32'(start), 32'h1);

    // 4: RUN mode 0 -> mode 1 while block 0 stays busy for 5 DRAIN cycles.
    busy = 3'b001;
    sel  = 3'b010;
    step(Latency - 1);
    check_eq("t4_start_hold", 32'(start), 32'h1);
    step(1);
    check_eq("t4_start_break", 32'(start), 32'h0);
    check_eq("t4_switching", 32'(switching), 32'h1);
    check_eq("t4_mode_chg", 32'(mode_chg), 32'h1);
    check_eq("t4_mode_valid", 32'(mode_valid), 32'h0);
    step(5);
    check_eq("t4_drain_start", 32'(start), 32'h0);
    check_eq("t4_drain_switching", 32'(switching), 32'h1);
    busy = 3'b000;
    step(1);
    check_eq("t4_start_make", 32'(start), 32'h2);
    check_eq("t4_make_chg", 32'(mode_chg), 32'h1);
    check_eq("t4_active_mode", 32'(active_mode), 32'h1);
    check_eq("t4_switching_end", 32'(switching), 32'h0);

    // 5: RUN mode 1 -> all switches off, block idle -> DRAIN then IDLE.
    sel = 3'b000;
    step(Latency - 1);
    check_eq("t5_start_hold", 32'(start), 32'h2);
    step(1);
    check_eq("t5_start_break", 32'(start), 32'h0);
    check_eq("t5_switching", 32'(switching), 32'h1);
    step(1);
    check_eq("t5_idle_switching", 32'(switching), 32'h0);
    check_eq("t5_idle_start", 32'(start), 32'h0);
    check_eq("t5_idle_mode_valid", 32'(mode_valid), 32'h0);
    check_eq("t5_idle_active_mode", 32'(active_mode), 32'h0);
    check_eq("t5_idle_mode_chg", 32'(mode_chg), 32'h0);

    // 3: two switches on from IDLE, the higher index wins.
    sel = 3'b110;
    step(Latency);
    check_eq("t3_start", 32'(start), 32'h4);
    check_eq("t3_active_mode", 32'(active_mode), 32'h2);
    check_eq("t3_mode_valid", 32'(mode_valid), 32'h1);
    check_eq("t3_mode_chg", 32'(mode_chg), 32'h1);

    // 6: RUN mode 2 -> mode 0 with busy[2] stuck high.
    busy = 3'b100;
    sel  = 3'b001;
    step(Latency);
    check_eq("t6_start_break", 32'(start), 32'h0);
    check_eq("t6_switching", 32'(switching), 32'h1);
`ifdef FPGA_MODE_TIMEOUT_EN
    step(TmoCyc - 1);
    check_eq("t6_pre_timeout_start", 32'(start), 32'h0);
    check_eq("t6_pre_timeout_err", 32'(timeout_err), 32'h0);
    step(1);
    check_eq("t6_timeout_start", 32'(start), 32'h1);
    check_eq("t6_timeout_err", 32'(timeout_err), 32'h1);
    check_eq("t6_timeout_active", 32'(active_mode), 32'h0);
    step(3);
    check_eq("t6_err_sticky", 32'(timeout_err), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_err_cleared", 32'(timeout_err), 32'h0);
    check_eq("t6_rst_start", 32'(start), 32'h0);
`else
    step(TmoCyc + 12);
    check_eq("t6_stuck_switching", 32'(switching), 32'h1);
    check_eq("t6_stuck_start", 32'(start), 32'h0);
    // Asynchronous reset in the middle of DRAIN.
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_switching", 32'(switching), 32'h0);
    check_eq("t6_rst_start", 32'(start), 32'h0);
`endif

    // Reset in the middle of debouncing restarts the full latency.
    busy = 3'b000;
    sel  = 3'b010;
    step(1);
    rst_n = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    check_eq("rdb_rst_start", 32'(start), 32'h0);
    rst_n = 1'b1;
    step(Latency - 1);
    check_eq("rdb_start_early", 32'(start), 32'h0);
    step(1);
    check_eq("rdb_start", 32'(start), 32'h2);
    check_eq("rdb_active_mode", 32'(active_mode), 32'h1);

    check_eq("never_multi_hot", 32'(multi_hot), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
